// File: rtl/coherence_bus_arbiter.sv
// Round-robin snoopy bus arbiter for two CPU caches: snoops the peer,
// orders invalidates and selects the data source before granting.
module coherence_bus_arbiter #(
   parameter int SNOOP_CYCLES = 2,
   parameter int ADDR_W       = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu0_read_miss,
   input  logic              cpu0_write_miss,
   input  logic              cpu0_invalidate,
   input  logic [ADDR_W-1:0] cpu0_addr,
   input  logic              cpu0_search_found,
   input  logic              cpu1_read_miss,
   input  logic              cpu1_write_miss,
   input  logic              cpu1_invalidate,
   input  logic [ADDR_W-1:0] cpu1_addr,
   input  logic              cpu1_search_found,
   input  logic              mem_rdy,
   output logic              cpu0_grant,
   output logic              cpu0_search,
   output logic [1:0]        cpu0_datasel,
   output logic              cpu0_inval_other,
   output logic              cpu1_grant,
   output logic              cpu1_search,
   output logic [1:0]        cpu1_datasel,
   output logic              cpu1_inval_other,
   output logic [ADDR_W-1:0] boci,
   output logic              mem_req,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_SNOOP, S_INVAL, S_XFER, S_MEM, S_GRANT
   } state_e;

   typedef enum logic [1:0] {
      T_INV = 2'd0, T_RM = 2'd1, T_WM = 2'd2
   } req_e;

   localparam logic [3:0] CNT_LAST = 4'(SNOOP_CYCLES - 1);

   logic [1:0] rm, wm, inv, req;

   assign rm  = {cpu1_read_miss, cpu0_read_miss};
   assign wm  = {cpu1_write_miss, cpu0_write_miss};
   assign inv = {cpu1_invalidate, cpu0_invalidate};
   assign req = rm | wm | inv;

   state_e            state_q, state_d;
   req_e              typ_q, typ_d;
   logic              win_q, win_d;
   logic              rr_q, rr_d;
   logic              found_q, found_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [1:0]        src_q, src_d;
   logic [ADDR_W-1:0] boci_q, boci_d;
   logic [1:0]        grant_q, grant_d;
   logic [1:0]        search_q, search_d;
   logic [1:0]        inval_q, inval_d;
   logic [1:0]        ds0_q, ds0_d;
   logic [1:0]        ds1_q, ds1_d;
   logic              mem_req_q, mem_req_d;

   logic              pick;
   req_e              pick_typ;
   logic              found_now;
   logic              win_pend;
   logic [1:0]        src_out;

   // Tie goes to the CPU that did not win last.
   assign pick      = (req == 2'b11) ? ~rr_q : req[1];
   assign pick_typ  = wm[pick] ? T_WM : (rm[pick] ? T_RM : T_INV);
   assign found_now = found_q |
                      (win_q ? cpu0_search_found : cpu1_search_found);

   always_comb begin
      win_pend = inv[win_q];
      if (typ_q == T_WM) win_pend = wm[win_q];
      else if (typ_q == T_RM) win_pend = rm[win_q];
   end

   always_comb begin
      state_d = state_q;
      typ_d   = typ_q;
      win_d   = win_q;
      rr_d    = rr_q;
      found_d = found_q;
      cnt_d   = cnt_q;
      src_d   = src_q;
      boci_d  = boci_q;

      unique case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               win_d   = pick;
               typ_d   = pick_typ;
               boci_d  = pick ? cpu1_addr : cpu0_addr;
               cnt_d   = '0;
               found_d = 1'b0;
               src_d   = 2'b00;
               state_d = S_SNOOP;
            end
         end
         S_SNOOP: begin
            found_d = found_now;
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (typ_q == T_RM) begin
                  state_d = found_now ? S_XFER : S_MEM;
                  src_d   = found_now ? 2'b10 : 2'b01;
               end else begin
                  state_d = S_INVAL;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_INVAL: begin
            if (typ_q == T_INV) begin
               state_d = S_GRANT;
               src_d   = 2'b00;
            end else begin
               state_d = found_q ? S_XFER : S_MEM;
               src_d   = found_q ? 2'b10 : 2'b01;
            end
         end
         S_XFER: state_d = S_GRANT;
         S_MEM: begin
            if (mem_rdy) state_d = S_GRANT;
         end
         S_GRANT: begin
            if (!win_pend) begin
               state_d = S_IDLE;
               rr_d    = win_q;
               boci_d  = '0;
               src_d   = 2'b00;
               found_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register with it.
   always_comb begin
      grant_d   = 2'b00;
      search_d  = 2'b00;
      inval_d   = 2'b00;
      mem_req_d = (state_d == S_MEM);
      src_out   = 2'b00;
      if (state_d == S_GRANT) grant_d[win_d] = 1'b1;
      if (state_d == S_SNOOP) search_d[~win_d] = 1'b1;
      if (state_d == S_INVAL) inval_d[~win_d] = 1'b1;
      if (state_d == S_XFER || state_d == S_MEM ||
          state_d == S_GRANT) src_out = src_d;
      ds0_d = win_d ? 2'b00 : src_out;
      ds1_d = win_d ? src_out : 2'b00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         typ_q     <= T_INV;
         win_q     <= 1'b0;
         rr_q      <= 1'b1;
         found_q   <= 1'b0;
         cnt_q     <= '0;
         src_q     <= 2'b00;
         boci_q    <= '0;
         grant_q   <= 2'b00;
         search_q  <= 2'b00;
         inval_q   <= 2'b00;
         ds0_q     <= 2'b00;
         ds1_q     <= 2'b00;
         mem_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         typ_q     <= typ_d;
         win_q     <= win_d;
         rr_q      <= rr_d;
         found_q   <= found_d;
         cnt_q     <= cnt_d;
         src_q     <= src_d;
         boci_q    <= boci_d;
         grant_q   <= grant_d;
         search_q  <= search_d;
         inval_q   <= inval_d;
         ds0_q     <= ds0_d;
         ds1_q     <= ds1_d;
         mem_req_q <= mem_req_d;
      end
   end

   assign cpu0_grant       = grant_q[0];
   assign cpu1_grant       = grant_q[1];
   assign cpu0_search      = search_q[0];
   assign cpu1_search      = search_q[1];
   assign cpu0_inval_other = inval_q[0];
   assign cpu1_inval_other = inval_q[1];
   assign cpu0_datasel     = ds0_q;
   assign cpu1_datasel     = ds1_q;
   assign boci             = boci_q;
   assign mem_req          = mem_req_q;
   assign busy             = (state_q != S_IDLE);

endmodule
